// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encodings,
// master index constants and the default abort read data.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// PicoRV32-style native valid/ready memory bus. The requester drives the
// request fields through the master modport; the responder uses slave.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              mem_valid;
  logic              mem_instr;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to the master that was not granted last.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    grant_valid = |req;
    grant       = M0;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = M1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory_driver port between two masters: round-robin selection,
// registered request hold, one-cycle ready pulse and a watchdog abort.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                TIMEOUT  = 64,
  parameter logic [ADDR_W-1:0] ERR_DATA = ADDR_W'(DEFAULT_ERR_DATA)
) (
  input  logic          clk,
  input  logic          resetn,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master ram,
  output logic          timeout_err
);

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t            state;
  logic              grant;
  logic              last_grant;
  logic [WD_W-1:0]   watchdog;
  logic [1:0]        req;
  logic              arb_grant;
  logic              arb_valid;
  logic              finish;
  logic [ADDR_W-1:0] resp_data;

  assign req = {m1.mem_valid, m0.mem_valid};

  rr_arbiter2 u_rr (
    .req         (req),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // A real completion beats the watchdog when both land on the same cycle.
  assign finish    = ram.mem_ready || (watchdog == WD_LAST);
  assign resp_data = ram.mem_ready ? ram.mem_rdata : ERR_DATA;

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      state         <= IDLE;
      grant         <= M0;
      last_grant    <= M1;
      watchdog      <= '0;
      timeout_err   <= 1'b0;
      ram.mem_valid <= 1'b0;
      ram.mem_instr <= 1'b0;
      ram.mem_addr  <= '0;
      ram.mem_wdata <= '0;
      ram.mem_wstrb <= '0;
      m0.mem_ready  <= 1'b0;
      m0.mem_rdata  <= '0;
      m1.mem_ready  <= 1'b0;
      m1.mem_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            ram.mem_valid <= 1'b1;
            ram.mem_instr <= (arb_grant == M0) ? m0.mem_instr : m1.mem_instr;
            ram.mem_addr  <= (arb_grant == M0) ? m0.mem_addr  : m1.mem_addr;
            ram.mem_wdata <= (arb_grant == M0) ? m0.mem_wdata : m1.mem_wdata;
            ram.mem_wstrb <= (arb_grant == M0) ? m0.mem_wstrb : m1.mem_wstrb;
            grant         <= arb_grant;
            last_grant    <= arb_grant;
            watchdog      <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          watchdog <= watchdog + 1'b1;
          if (finish) begin
            if (grant == M0) begin
              m0.mem_ready <= 1'b1;
              m0.mem_rdata <= resp_data;
            end else begin
              m1.mem_ready <= 1'b1;
              m1.mem_rdata <= resp_data;
            end
            if (!ram.mem_ready) begin
              timeout_err <= 1'b1;
            end
            ram.mem_valid <= 1'b0;
            state         <= DONE;
          end
        end
        DONE: begin
          // Turnaround cycle: the served master drops valid before the next arbitration.
          m0.mem_ready <= 1'b0;
          m0.mem_rdata <= '0;
          m1.mem_ready <= 1'b0;
          m1.mem_rdata <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: master drivers push expected rdata into
// per-master scoreboards, a RAM model responds, and a monitor pops on ready.
module tb_mem_arbiter;

  localparam logic [31:0] ERR_VALUE = 32'hDEAD_BEEF;
  localparam logic [31:0] RAM_KEY   = 32'hC0DE_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic [31:0] exp;
  } req_t;

  logic clk;
  logic resetn;
  logic timeout_err;

  mem_arbiter_if #(.ADDR_W(32)) m0_bus ();
  mem_arbiter_if #(.ADDR_W(32)) m1_bus ();
  mem_arbiter_if #(.ADDR_W(32)) ram_bus ();

  mem_arbiter #(
    .ADDR_W   (32),
    .TIMEOUT  (64),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m0          (m0_bus),
    .m1          (m1_bus),
    .ram         (ram_bus),
    .timeout_err (timeout_err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  req_t        req0_q[$];
  req_t        req1_q[$];
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  int          served[$];
  int          raise_cyc[2];
  int          ready_cyc[2];
  int          ram_rise_cyc;
  int          ram_latency    = 2;
  bit          ram_never      = 0;
  bit          ram_force_en   = 0;
  logic [31:0] ram_force_data = '0;
  int          ram_cnt        = 0;
  logic        ram_prev_valid = 1'b0;
  logic [68:0] ram_snap       = '0;
  req_t        r0;
  req_t        r1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input int m, input logic [31:0] rdata);
    int sz;
    logic [31:0] e;
    sz = (m == 0) ? exp0_q.size() : exp1_q.size();
    n_checks++;
    assert (sz > 0) else begin
      n_fail++;
      $error("FAIL m%0d_unexpected_ready: observed ready=1 rdata=%0h, expected no pending request", m, rdata);
    end
    if (sz > 0) begin
      e = (m == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
      check($sformatf("m%0d_rdata", m), rdata, e);
      served.push_back(m);
      ready_cyc[m] = cyc;
    end
  endtask

  function automatic req_t mk_req(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wstrb, input logic [31:0] exp);
    req_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.wstrb = wstrb;
    r.instr = addr[4];
    r.exp   = exp;
    return r;
  endfunction

  // Master 0 driver: drops valid on ready, raises the next queued request.
  initial begin
    m0_bus.mem_valid = 1'b0; m0_bus.mem_instr = 1'b0; m0_bus.mem_addr = '0;
    m0_bus.mem_wdata = '0;   m0_bus.mem_wstrb = '0;
    forever begin
      @(negedge clk);
      if (m0_bus.mem_valid && m0_bus.mem_ready) begin
        m0_bus.mem_valid = 1'b0;
      end else if (!m0_bus.mem_valid && req0_q.size() > 0) begin
        r0 = req0_q.pop_front();
        m0_bus.mem_addr  = r0.addr;
        m0_bus.mem_wdata = r0.wdata;
        m0_bus.mem_wstrb = r0.wstrb;
        m0_bus.mem_instr = r0.instr;
        m0_bus.mem_valid = 1'b1;
        exp0_q.push_back(r0.exp);
        raise_cyc[0] = cyc;
      end
    end
  end

  // Master 1 driver.
  initial begin
    m1_bus.mem_valid = 1'b0; m1_bus.mem_instr = 1'b0; m1_bus.mem_addr = '0;
    m1_bus.mem_wdata = '0;   m1_bus.mem_wstrb = '0;
    forever begin
      @(negedge clk);
      if (m1_bus.mem_valid && m1_bus.mem_ready) begin
        m1_bus.mem_valid = 1'b0;
      end else if (!m1_bus.mem_valid && req1_q.size() > 0) begin
        r1 = req1_q.pop_front();
        m1_bus.mem_addr  = r1.addr;
        m1_bus.mem_wdata = r1.wdata;
        m1_bus.mem_wstrb = r1.wstrb;
        m1_bus.mem_instr = r1.instr;
        m1_bus.mem_valid = 1'b1;
        exp1_q.push_back(r1.exp);
        raise_cyc[1] = cyc;
      end
    end
  end

  // RAM model: ready after ram_latency cycles of valid, request held stable meanwhile.
  initial begin
    ram_bus.mem_ready = 1'b0;
    ram_bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (ram_bus.mem_valid && ram_prev_valid)
        check("ram_stable",
              {ram_bus.mem_instr, ram_bus.mem_addr, ram_bus.mem_wdata, ram_bus.mem_wstrb}, ram_snap);
      if (ram_bus.mem_valid && !ram_prev_valid) ram_rise_cyc = cyc;
      ram_prev_valid = ram_bus.mem_valid;
      ram_snap = {ram_bus.mem_instr, ram_bus.mem_addr, ram_bus.mem_wdata, ram_bus.mem_wstrb};
      if (ram_bus.mem_ready) begin
        ram_bus.mem_ready = 1'b0;
        ram_cnt = 0;
      end else if (ram_bus.mem_valid) begin
        ram_cnt++;
        if (!ram_never && ram_cnt == ram_latency) begin
          ram_bus.mem_ready = 1'b1;
          ram_bus.mem_rdata = ram_force_en ? ram_force_data : (ram_bus.mem_addr ^ RAM_KEY);
        end
      end else begin
        ram_cnt = 0;
      end
    end
  end

  // Ready monitor: one scoreboard pop per observed ready cycle.
  initial forever begin
    @(negedge clk);
    if (m0_bus.mem_ready === 1'b1) sb_pop(0, m0_bus.mem_rdata);
    if (m1_bus.mem_ready === 1'b1) sb_pop(1, m1_bus.mem_rdata);
  end

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((req0_q.size() > 0 || req1_q.size() > 0 || exp0_q.size() > 0 || exp1_q.size() > 0 ||
            m0_bus.mem_valid || m1_bus.mem_valid) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_checks++;
    assert (n < budget) else begin
      n_fail++;
      $error("FAIL %s_drain: waited %0d cycles, limit %0d", tag, n, budget);
    end
  endtask

  task automatic wait_ram_valid(input string tag, input int budget);
    int n = 0;
    while (!ram_bus.mem_valid && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_checks++;
    assert (n < budget) else begin
      n_fail++;
      $error("FAIL %s_ram_valid: waited %0d cycles, limit %0d", tag, n, budget);
    end
  endtask

  initial begin
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ram_valid", ram_bus.mem_valid, 1'b0);
    check("reset_ram_addr", ram_bus.mem_addr, 32'h0);
    check("reset_m0_ready", m0_bus.mem_ready, 1'b0);
    check("reset_m1_ready", m1_bus.mem_ready, 1'b0);
    check("reset_timeout_err", timeout_err, 1'b0);
    #1 resetn = 1'b1;

    // Single read with forced data and 3-cycle latency.
    ram_latency = 3; ram_force_en = 1; ram_force_data = 32'h1234_5678;
    req0_q.push_back(mk_req(32'h0000_0040, 32'h0, 4'b0000, 32'h1234_5678));
    wait_drain("read", 50);
    check("read_valid_latency", ram_rise_cyc - raise_cyc[0], 1);
    check("read_ready_latency", ready_cyc[0] - ram_rise_cyc, 3);
    ram_force_en = 0;

    // Write pass-through from m1.
    ram_latency = 2;
    req1_q.push_back(mk_req(32'h0000_1000, 32'hA5A5_0001, 4'b0011, 32'h0000_1000 ^ RAM_KEY));
    wait_ram_valid("write", 20);
    check("write_addr", ram_bus.mem_addr, 32'h0000_1000);
    check("write_wdata", ram_bus.mem_wdata, 32'hA5A5_0001);
    check("write_wstrb", ram_bus.mem_wstrb, 4'b0011);
    check("write_instr", ram_bus.mem_instr, 1'b0);
    wait_drain("write", 50);

    // Tie with immediate re-requests: round-robin order.
    served.delete();
    ram_latency = 1;
    req0_q.push_back(mk_req(32'h0000_0100, 32'h0, 4'b0000, 32'h0000_0100 ^ RAM_KEY));
    req0_q.push_back(mk_req(32'h0000_0110, 32'h0, 4'b0000, 32'h0000_0110 ^ RAM_KEY));
    req1_q.push_back(mk_req(32'h0000_0200, 32'h0, 4'b0000, 32'h0000_0200 ^ RAM_KEY));
    req1_q.push_back(mk_req(32'h0000_0210, 32'h7, 4'b1111, 32'h0000_0210 ^ RAM_KEY));
    wait_drain("tie", 200);
    check("tie_count", served.size(), 4);
    for (int i = 0; i < 4 && i < served.size(); i++)
      check($sformatf("tie_grant%0d", i), served[i], i % 2);

    // Ready on the last watchdog cycle: real data, no error.
    ram_latency = 64;
    req0_q.push_back(mk_req(32'h0000_0080, 32'h0, 4'b0000, 32'h0000_0080 ^ RAM_KEY));
    wait_drain("lastcycle", 200);
    check("lastcycle_latency", ready_cyc[0] - ram_rise_cyc, 64);
    check("lastcycle_timeout_err", timeout_err, 1'b0);

    // Timeout abort, then a normal m1 transaction.
    ram_never = 1;
    req0_q.push_back(mk_req(32'h0000_0200, 32'h0, 4'b0000, ERR_VALUE));
    wait_drain("timeout", 200);
    check("timeout_latency", ready_cyc[0] - ram_rise_cyc, 64);
    check("timeout_err_set", timeout_err, 1'b1);
    ram_never = 0; ram_latency = 2;
    req1_q.push_back(mk_req(32'h0000_0300, 32'h0, 4'b0000, 32'h0000_0300 ^ RAM_KEY));
    wait_drain("after_timeout", 50);
    check("timeout_err_sticky", timeout_err, 1'b1);

    // Reset in the middle of a BUSY transaction.
    ram_never = 1;
    req0_q.push_back(mk_req(32'h0000_0400, 32'h0, 4'b0000, 32'h0));
    wait_ram_valid("midreset", 20);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midreset_ram_valid", ram_bus.mem_valid, 1'b0);
    check("midreset_ram_addr", ram_bus.mem_addr, 32'h0);
    check("midreset_ram_wdata", ram_bus.mem_wdata, 32'h0);
    check("midreset_ram_wstrb", ram_bus.mem_wstrb, 4'b0000);
    check("midreset_m0_ready", m0_bus.mem_ready, 1'b0);
    check("midreset_timeout_err", timeout_err, 1'b0);
    m0_bus.mem_valid = 1'b0;
    exp0_q.delete();
    served.delete();
    ram_never = 0; ram_latency = 2;
    req0_q.push_back(mk_req(32'h0000_0500, 32'h0, 4'b0000, 32'h0000_0500 ^ RAM_KEY));
    req1_q.push_back(mk_req(32'h0000_0600, 32'h0, 4'b0000, 32'h0000_0600 ^ RAM_KEY));
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    wait_drain("post_reset", 100);
    check("post_reset_count", served.size(), 2);
    if (served.size() == 2) begin
      check("post_reset_first", served[0], 0);
      check("post_reset_second", served[1], 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter that shares the single main-memory port (memory_driver, SIZE=14, WIDTH=32) between requesters using the PicoRV32 native valid/ready bus.
- Typical masters: the cache_direct refill/write-back port (m0) and a second engine, e.g. a display/DMA reader (m1).
- Sits between the masters and memory_driver, serialises transactions with round-robin fairness, and bounds every transaction with a watchdog timeout.

Parameters:
- ADDR_W, 32, address/data width of all buses.
- TIMEOUT, 64, max cycles to wait for ram_mem_ready before aborting (>=2).
- ERR_DATA, 32'hDEAD_BEEF, rdata returned to master on timeout abort.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m0_mem_valid / m1_mem_valid  in  1  master request.
- m0_mem_instr / m1_mem_instr  in  1  instruction-fetch flag.
- m0_mem_addr / m1_mem_addr  in  ADDR_W  byte address.
- m0_mem_wdata / m1_mem_wdata  in  ADDR_W  write data.
- m0_mem_wstrb / m1_mem_wstrb  in  4  byte strobes; 0 = read.
- m0_mem_ready / m1_mem_ready  out  1  one-cycle completion pulse.
- m0_mem_rdata / m1_mem_rdata  out  ADDR_W  read data, valid while ready=1.
- ram_mem_valid  out  1  request to memory_driver (registered).
- ram_mem_instr  out  1  latched instr flag.
- ram_mem_addr  out  ADDR_W  latched address.
- ram_mem_wdata  out  ADDR_W  latched write data.
- ram_mem_wstrb  out  4  latched strobes.
- ram_mem_ready  in  1  memory completion.
- ram_mem_rdata  in  ADDR_W  memory read data.
- timeout_err  out  1  sticky flag, set on any abort.

Behaviour:
- Reset (async, resetn=0): state=IDLE; ram_mem_valid=0; ram_mem_addr/wdata/wstrb/instr=0; m0/m1_mem_ready=0; m0/m1_mem_rdata=0; timeout_err=0; last_grant=1, so m0 wins the first tie; watchdog=0.
- A reset mid-transaction drops ram_mem_valid immediately. No ready is issued to the pending master.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any mX_mem_valid=1, select a winner: the lone requester, or on a tie the master != last_grant.
  - Latch the winner's instr/addr/wdata/wstrb into the ram_* registers, set ram_mem_valid=1, grant=winner, last_grant=winner, watchdog=0, go to BUSY.
  - Latency: valid sampled at edge N gives ram_mem_valid=1 after edge N.
- BUSY:
  - ram_* outputs are held stable; later changes on master inputs are ignored. watchdog increments each cycle.
  - If ram_mem_ready=1: register m<grant>_mem_ready=1 and m<grant>_mem_rdata=ram_mem_rdata (rdata captured for writes too). Clear ram_mem_valid and go to DONE.
  - Else if watchdog==TIMEOUT-1: abort. Register m<grant>_mem_ready=1, rdata=ERR_DATA, set timeout_err=1, clear ram_mem_valid, go to DONE.
  - ram_mem_ready and timeout on the same cycle: ready wins, no error.
- DONE (1 cycle):
  - ready pulse is visible this cycle; ready and rdata return to 0 on the next edge.
  - Go to IDLE. This turnaround guarantees the served master has dropped valid before the next arbitration, so a stale request is never regranted.
- The non-granted master never sees ready; its request waits with valid held, and is served next under round-robin.
- Worst-case wait for a requester: one other full transaction.
- ram_mem_ready arriving while not in BUSY is ignored.
- timeout_err clears only on reset.

Decomposition:
- Shared package (or define header): FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), default ERR_DATA, and the master index constants M0=0 and M1=1.
- One natural sub-module: rr_arbiter2. It is combinational and takes req[1:0] and last_grant, and returns grant and grant_valid. This allows an N-master upgrade later.
- Request muxing, the FSM and the watchdog stay in mem_arbiter.

Test Plan:
- Single read: m0 reads addr 32'h0000_0040 with wstrb=0; the RAM model returns 32'h1234_5678 after 3 cycles. Required: ram_mem_valid rises 1 cycle after m0 valid; m0_mem_ready pulses exactly 1 cycle with rdata=32'h1234_5678; m1_mem_ready stays 0.
- Write pass-through: m1 writes wdata=32'hA5A5_0001, wstrb=4'b0011, addr 32'h0000_1000. Required: ram_* carry exactly these values, stable until ram_mem_ready; m1_mem_ready pulses once.
- Tie / round-robin: m0 and m1 assert valid on the same cycle, each re-requesting immediately after service, for 4 transactions. Required grant order: m0, m1, m0, m1.
- Timeout: m0 reads and the RAM model never asserts ready. Required: after TIMEOUT=64 cycles in BUSY, m0_mem_ready pulses with rdata=32'hDEAD_BEEF, timeout_err=1 and stays set. The next m1 request is served normally.
- Ready on the last watchdog cycle: ram_mem_ready arrives on cycle TIMEOUT-1. Required: real rdata is returned and timeout_err stays 0.
- Reset mid-transaction: pull resetn low while in BUSY. Required: all outputs go to 0 asynchronously. After release, a pending m0 and m1 tie grants m0 first.
